// File: rtl/avsdpll_lock_detect.sv
// avsdpll_lock_detect: counts PLL CLK cycles per REF period and declares lock
// after a run of in-tolerance periods, drops it on bad periods or REF loss.
module avsdpll_lock_detect #(
    parameter int MULT         = 8,
    parameter int TOL          = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             REF,
    output logic [CNT_W-1:0] COUNT,
    output logic             MEAS_VALID,
    output logic             FREQ_HI,
    output logic             FREQ_LO,
    output logic             LOCK,
    output logic             ERR
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] LO_B   = CNT_W'((TOL >= MULT) ? 0 : MULT - TOL);
    localparam logic [CNT_W-1:0] HI_B   = CNT_W'(MULT + TOL);
    localparam logic [GW-1:0]    G_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]    B_LAST = BW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, ACQUIRE, LOCKED} state_t;

    state_t           state, state_n;
    logic             s1, s2, s3, redge, sat, good, hi;
    logic             mv_n, hi_n, lo_n, lock_n, err_n;
    logic [CNT_W-1:0] cnt, cnt_n, count_n, d;
    logic [GW-1:0]    good_cnt, good_n;
    logic [BW-1:0]    bad_cnt, bad_n;

    assign redge = s2 & ~s3;
    assign sat   = cnt == MAX;
    // cnt already includes the redge cycle, so at redge it equals the period
    assign d     = cnt - LO_B;
    assign good  = d <= HI_B - LO_B;
    assign hi    = cnt > HI_B;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            {s1, s2, s3} <= '0;
            state      <= IDLE;
            cnt        <= '0;
            COUNT      <= '0;
            MEAS_VALID <= 1'b0;
            FREQ_HI    <= 1'b0;
            FREQ_LO    <= 1'b0;
            LOCK       <= 1'b0;
            ERR        <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            {s1, s2, s3} <= {REF, s1, s2};
            state      <= state_n;
            cnt        <= cnt_n;
            COUNT      <= count_n;
            MEAS_VALID <= mv_n;
            FREQ_HI    <= hi_n;
            FREQ_LO    <= lo_n;
            LOCK       <= lock_n;
            ERR        <= err_n;
            good_cnt   <= good_n;
            bad_cnt    <= bad_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = redge ? CNT_W'(1) : sat ? cnt : cnt + 1'b1;
        count_n = COUNT;
        mv_n    = 1'b0;
        hi_n    = FREQ_HI;
        lo_n    = FREQ_LO;
        lock_n  = LOCK;
        err_n   = ERR;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        if (!EN) begin
            state_n = IDLE;
            cnt_n   = '0;
            count_n = '0;
            hi_n    = 1'b0;
            lo_n    = 1'b0;
            lock_n  = 1'b0;
            err_n   = 1'b0;
            good_n  = '0;
            bad_n   = '0;
        end else if (state == IDLE) begin
            state_n = WAIT_EDGE;
            cnt_n   = '0;
        end else if (state == WAIT_EDGE) begin
            state_n = redge ? ACQUIRE : WAIT_EDGE;
        end else if (redge && ERR) begin
            err_n = 1'b0;
        end else if (redge) begin
            count_n = cnt;
            mv_n    = 1'b1;
            hi_n    = hi;
            lo_n    = !good && !hi;
            if (state == ACQUIRE) begin
                good_n = good ? good_cnt + 1'b1 : '0;
                if (good && good_cnt == G_LAST) begin
                    state_n = LOCKED;
                    lock_n  = 1'b1;
                    good_n  = '0;
                end
            end else begin
                bad_n = good ? '0 : bad_cnt + 1'b1;
                if (!good && bad_cnt == B_LAST) begin
                    state_n = ACQUIRE;
                    lock_n  = 1'b0;
                    bad_n   = '0;
                    good_n  = '0;
                end
            end
        end else if (sat) begin
            // REF lost: the next edge restarts the period without a measurement
            state_n = ACQUIRE;
            err_n   = 1'b1;
            lock_n  = 1'b0;
            good_n  = '0;
            bad_n   = '0;
        end
    end
endmodule

// File: tb/tb_avsdpll_lock_detect.sv
// tb_avsdpll_lock_detect: directed scenarios for the PLL lock detector with
// REF driven as whole-CLK periods, plus one jittered asynchronous REF run.
module tb_avsdpll_lock_detect;
    logic       CLK, RST, EN, REF;
    logic [7:0] COUNT;
    logic       MEAS_VALID, FREQ_HI, FREQ_LO, LOCK, ERR;

    int   n_cmp = 0, n_bad = 0, mv_total = 0;
    logic lock_at_mv = 1'b0;

    avsdpll_lock_detect dut (
        .CLK(CLK), .RST(RST), .EN(EN), .REF(REF), .COUNT(COUNT),
        .MEAS_VALID(MEAS_VALID), .FREQ_HI(FREQ_HI), .FREQ_LO(FREQ_LO),
        .LOCK(LOCK), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MEAS_VALID) begin
            mv_total   <= mv_total + 1;
            lock_at_mv <= LOCK;
        end
    end

    // one REF period of n CLK cycles, rising at the start
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            REF = (i < n / 2);
            @(negedge CLK);
        end
    endtask

    task automatic restart();
        EN = 1'b0;
        @(negedge CLK);
        EN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; REF = 1'b0;
        repeat (6) begin @(negedge CLK); REF = ~REF; end
        #1;
        n_cmp++; if ({COUNT, MEAS_VALID, FREQ_HI, FREQ_LO, LOCK, ERR} !== 13'd0) begin n_bad++; $display("FAIL reset_outputs: got %h, expected 0", {COUNT, MEAS_VALID, FREQ_HI, FREQ_LO, LOCK, ERR}); end
        n_cmp++; if (mv_total != 0) begin n_bad++; $display("FAIL reset_no_meas: got %0d, expected 0", mv_total); end
        REF = 1'b0;
        @(negedge CLK);
        RST = 1'b0; EN = 1'b1;
    endtask

    task automatic test_lock();
        int base = mv_total;
        run(8); #1;
        n_cmp++; if (mv_total - base != 0) begin n_bad++; $display("FAIL first_edge_discard: got %0d, expected 0", mv_total - base); end
        run(8); #1;
        n_cmp++; if (mv_total - base != 1) begin n_bad++; $display("FAIL first_meas_count: got %0d, expected 1", mv_total - base); end
        n_cmp++; if (COUNT !== 8'd8) begin n_bad++; $display("FAIL first_meas_value: got %0d, expected 8", COUNT); end
        n_cmp++; if ({FREQ_HI, FREQ_LO} !== 2'b00) begin n_bad++; $display("FAIL first_meas_flags: got %b, expected 00", {FREQ_HI, FREQ_LO}); end
        run(8); run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL lock_after_3: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (mv_total - base != 4) begin n_bad++; $display("FAIL meas_count_4: got %0d, expected 4", mv_total - base); end
        n_cmp++; if (lock_at_mv !== 1'b1) begin n_bad++; $display("FAIL lock_with_4th_mv: got %b, expected 1", lock_at_mv); end
        repeat (3) run(8); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL lock_held: got %b, expected 1", LOCK); end
    endtask

    task automatic test_tolerance();
        restart();
        run(7); run(9); #1;
        n_cmp++; if (COUNT !== 8'd7 || FREQ_LO !== 1'b0) begin n_bad++; $display("FAIL tol_meas_7: got count %0d lo %b, expected 7 0", COUNT, FREQ_LO); end
        run(7); run(9); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL tol_lock_after_3: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1 || COUNT !== 8'd9) begin n_bad++; $display("FAIL tol_lock_7_9: got lock %b count %0d, expected 1 9", LOCK, COUNT); end
        restart();
        run(8); run(8); run(10); run(8); #1;
        n_cmp++; if (COUNT !== 8'd10 || FREQ_HI !== 1'b1 || FREQ_LO !== 1'b0) begin n_bad++; $display("FAIL tol_meas_10: got count %0d hi %b lo %b, expected 10 1 0", COUNT, FREQ_HI, FREQ_LO); end
        run(8); run(8); run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL tol_good_restart: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL tol_relock: got %b, expected 1", LOCK); end
        run(6); run(8); #1;
        n_cmp++; if (COUNT !== 8'd6 || FREQ_LO !== 1'b1 || FREQ_HI !== 1'b0) begin n_bad++; $display("FAIL tol_meas_6: got count %0d hi %b lo %b, expected 6 0 1", COUNT, FREQ_HI, FREQ_LO); end
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL tol_single_bad_keeps_lock: got %b, expected 1", LOCK); end
        run(8);
    endtask

    task automatic test_unlock();
        run(12); run(8); run(12); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL unlock_one_bad: got %b, expected 1", LOCK); end
        run(12); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL unlock_bad_cnt_reset: got %b, expected 1", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b0 || FREQ_HI !== 1'b1 || COUNT !== 8'd12) begin n_bad++; $display("FAIL unlock_two_bad: got lock %b hi %b count %0d, expected 0 1 12", LOCK, FREQ_HI, COUNT); end
        run(8); run(8); run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL unlock_relock_early: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL unlock_relock: got %b, expected 1", LOCK); end
    endtask

    task automatic test_ref_loss();
        int base, waited;
        REF = 1'b0;
        repeat (245) @(negedge CLK);
        #1;
        n_cmp++; if (ERR !== 1'b0 || LOCK !== 1'b1) begin n_bad++; $display("FAIL loss_too_early: got err %b lock %b, expected 0 1", ERR, LOCK); end
        waited = 0;
        while (!ERR && waited < 20) begin @(negedge CLK); #1; waited++; end
        n_cmp++; if (ERR !== 1'b1 || LOCK !== 1'b0) begin n_bad++; $display("FAIL loss_err: got err %b lock %b after %0d cycles, expected 1 0", ERR, LOCK, waited); end
        base = mv_total;
        run(8); #1;
        n_cmp++; if (ERR !== 1'b0 || mv_total != base) begin n_bad++; $display("FAIL loss_resume_edge: got err %b meas %0d, expected 0 0", ERR, mv_total - base); end
        run(8); run(8); run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL loss_relock_early: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1 || COUNT !== 8'd8) begin n_bad++; $display("FAIL loss_relock: got lock %b count %0d, expected 1 8", LOCK, COUNT); end
    endtask

    task automatic test_en_rst();
        EN = 1'b0;
        @(negedge CLK); #1;
        n_cmp++; if (LOCK !== 1'b0 || COUNT !== 8'd0 || FREQ_HI !== 1'b0 || FREQ_LO !== 1'b0) begin n_bad++; $display("FAIL en_low_clears: got lock %b count %0d hi %b lo %b, expected 0 0 0 0", LOCK, COUNT, FREQ_HI, FREQ_LO); end
        EN = 1'b1;
        repeat (4) run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL en_relock_early: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL en_relock: got %b, expected 1", LOCK); end
        REF = 1'b1;
        @(negedge CLK); @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        n_cmp++; if ({COUNT, MEAS_VALID, FREQ_HI, FREQ_LO, LOCK, ERR} !== 13'd0) begin n_bad++; $display("FAIL rst_async: got %h, expected 0", {COUNT, MEAS_VALID, FREQ_HI, FREQ_LO, LOCK, ERR}); end
        REF = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) run(8); #1;
        n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL rst_relock_early: got %b, expected 0", LOCK); end
        run(8); #1;
        n_cmp++; if (LOCK !== 1'b1) begin n_bad++; $display("FAIL rst_relock: got %b, expected 1", LOCK); end
    endtask

    task automatic test_jitter();
        int  nm = 0;
        bit  seen = 1'b0, lost = 1'b0;
        restart();
        fork
            begin
                #($urandom_range(5, 14));
                for (int k = 0; k < 30; k++) begin
                    int j = int'($urandom_range(0, 8)) - 4;
                    #(4 + j) REF = 1'b1;
                    #40 REF = 1'b0;
                    #(36 - j);
                end
            end
            begin
                repeat (240) begin
                    @(negedge CLK);
                    if (MEAS_VALID) begin
                        nm++;
                        n_cmp++; if (COUNT < 8'd7 || COUNT > 8'd9) begin n_bad++; $display("FAIL jitter_range: got %0d, expected 7..9", COUNT); end
                    end
                    if (seen && !LOCK) lost = 1'b1;
                    if (LOCK) seen = 1'b1;
                end
            end
        join
        n_cmp++; if (nm < 25) begin n_bad++; $display("FAIL jitter_meas_count: got %0d, expected >=25", nm); end
        n_cmp++; if (!seen || lost) begin n_bad++; $display("FAIL jitter_lock: got seen %b lost %b, expected 1 0", seen, lost); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tolerance();
        test_unlock();
        test_ref_loss();
        test_en_rst();
        test_jitter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
